// File: rtl/moving_average_pkg.sv
// Shared sizing helpers for the boxcar moving-average filter.
package moving_average_pkg;

  // Running-sum width: DEPTH full-scale samples must fit without overflow.
  function automatic int unsigned sum_width(input int unsigned depth, input int unsigned data_w);
    return data_w + int'($clog2(depth + 1));
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

endpackage

// File: rtl/moving_average_filter_if.sv
// Sample stream bus for the moving-average filter: enable, input sample, averaged output.
interface moving_average_filter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              ena;
  logic [DATA_W-1:0] id;
  logic [DATA_W-1:0] od;

  modport master (output ena, output id, input od);
  modport slave  (input ena, input id, output od);
endinterface

// File: rtl/ma_delay_line.sv
// Circular delay line of DEPTH samples; presents the entry about to be overwritten.
module ma_delay_line
  import moving_average_pkg::*;
#(
  parameter int unsigned DEPTH  = 255,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ena,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout_oldest
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [DATA_W-1:0] line_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (ena) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Whole window clears on reset so averaging restarts from zeros.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        line_q[i] <= '0;
      end
    end else if (ena) begin
      line_q[wr_ptr_q] <= din;
    end
  end

  assign dout_oldest = line_q[wr_ptr_q];

endmodule

// File: rtl/moving_average_filter.sv
// Boxcar averager: running sum over the delay line, registered floor(sum / DEPTH).
module moving_average_filter
  import moving_average_pkg::*;
#(
  parameter int unsigned DEPTH  = 255,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   nrst,
  moving_average_filter_if.slave bus
);

  localparam int unsigned SUM_W = sum_width(DEPTH, DATA_W);

  logic [DATA_W-1:0] oldest;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W-1:0]  quot_c;
  logic [DATA_W-1:0] od_q;
  logic [DATA_W-1:0] od_d;

  ma_delay_line #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_line (
    .clk         (clk),
    .nrst        (nrst),
    .ena         (bus.ena),
    .din         (bus.id),
    .dout_oldest (oldest)
  );

  // Output divides the pre-update sum, giving the two-edge pipeline.
  always_comb begin
    sum_d  = sum_q;
    od_d   = od_q;
    quot_c = sum_q / SUM_W'(DEPTH);
    if (bus.ena) begin
      sum_d = sum_q + SUM_W'(bus.id) - SUM_W'(oldest);
      od_d  = DATA_W'(quot_c);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sum_q <= '0;
      od_q  <= '0;
    end else begin
      sum_q <= sum_d;
      od_q  <= od_d;
    end
  end

  assign bus.od = od_q;

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed and scoreboard checks for moving_average_filter at 255x32 and 5x8.
module tb_moving_average_filter;

  localparam logic [31:0] K  = 32'h0101_0101;
  localparam logic [31:0] FF = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  moving_average_filter_if #(.DATA_W(32)) bus_a ();
  moving_average_filter_if #(.DATA_W(8))  bus_b ();

  moving_average_filter #(.DEPTH(255), .DATA_W(32)) dut_a (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_a)
  );

  moving_average_filter #(.DEPTH(5), .DATA_W(8)) dut_b (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  int unsigned win[$];
  logic [7:0]  b_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < 5; i++) win.push_back(0);
    b_exp = 8'h00;
  endtask

  // Reference for the 5-deep instance: average of the window as it stood before the edge.
  task automatic model_b(input logic e, input logic [7:0] d);
    int unsigned s;
    if (e) begin
      s = 0;
      foreach (win[i]) s += win[i];
      b_exp = 8'(s / 5);
      win.push_back(int'(d));
      void'(win.pop_front());
    end
  endtask

  initial begin
    logic [7:0] wr_in  [8];
    logic [7:0] wr_exp [8];
    logic       e;
    logic [7:0] d;

    wr_in  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    wr_exp = '{8'd0,  8'd2,  8'd6,  8'd12, 8'd20, 8'd30, 8'd40, 8'd50};

    // Reset held with full-scale input enabled.
    nrst      = 1'b0;
    bus_a.ena = 1'b1;
    bus_a.id  = FF;
    bus_b.ena = 1'b0;
    bus_b.id  = 8'h00;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", 64'(bus_a.od), 64'(32'h0));
    end
    check("reset_b", 64'(bus_b.od), 64'(8'h0));

    nrst = 1'b1;
    tick();
    check("post_release", 64'(bus_a.od), 64'(32'h0));

    // Rising step: after edge n+1, od = n*K.
    for (int n = 1; n <= 255; n++) begin
      tick();
      check("ramp", 64'(bus_a.od), 64'(32'(n) * K));
    end
    for (int n = 257; n <= 300; n++) begin
      tick();
      check("plateau", 64'(bus_a.od), 64'(FF));
    end

    // Falling step.
    bus_a.id = 32'h0;
    tick();
    check("drop_first", 64'(bus_a.od), 64'(FF));
    for (int j = 0; j <= 254; j++) begin
      tick();
      check("fall", 64'(bus_a.od), 64'(32'(254 - j) * K));
    end
    tick();
    check("fall_floor", 64'(bus_a.od), 64'(32'h0));

    // Enable gating 1-on/2-off, with X on id while disabled.
    for (int e_cnt = 1; e_cnt <= 20; e_cnt++) begin
      bus_a.ena = 1'b1;
      bus_a.id  = FF;
      tick();
      check("gate_on", 64'(bus_a.od), 64'(32'(e_cnt - 1) * K));
      bus_a.ena = 1'b0;
      bus_a.id  = 'x;
      tick();
      check("gate_hold1", 64'(bus_a.od), 64'(32'(e_cnt - 1) * K));
      tick();
      check("gate_hold2", 64'(bus_a.od), 64'(32'(e_cnt - 1) * K));
    end
    bus_a.ena = 1'b1;
    bus_a.id  = FF;
    tick();
    check("gate_resume", 64'(bus_a.od), 64'(32'd20 * K));
    for (int i = 0; i < 259; i++) tick();
    check("plateau2", 64'(bus_a.od), 64'(FF));

    // Asynchronous mid-stream reset pulse, not aligned to the clock.
    #2;
    nrst = 1'b0;
    #2;
    check("async_reset", 64'(bus_a.od), 64'(32'h0));
    #3;
    nrst = 1'b1;
    tick();
    check("restart_0", 64'(bus_a.od), 64'(32'h0));
    tick();
    check("restart_1", 64'(bus_a.od), 64'(K));
    tick();
    check("restart_2", 64'(bus_a.od), 64'(32'd2 * K));
    bus_a.ena = 1'b0;

    // DEPTH=5 pointer wrap with hand-computed values.
    model_reset();
    bus_b.ena = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_b.id = wr_in[i];
      tick();
      model_b(1'b1, wr_in[i]);
      check("b_wrap", 64'(bus_b.od), 64'(wr_exp[i]));
    end

    // Random stream against the FIFO reference.
    for (int i = 0; i < 1000; i++) begin
      e         = ($urandom_range(0, 3) != 0);
      d         = 8'($urandom_range(0, 255));
      bus_b.ena = e;
      bus_b.id  = e ? d : 'x;
      tick();
      model_b(e, d);
      check("b_rand", 64'(bus_b.od), 64'(b_exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
